// File: rtl/keypad_reg_alu_pkg.sv
// keypad_reg_alu_pkg: opcodes, ALU states and keypad code constants shared by the keypad/register/ALU datapath.
package keypad_reg_alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_e;
  typedef enum logic [1:0] {IDLE, CAPT, EXEC} alu_state_e;
  localparam int KEY_W = 4;
  // Scan results carry an extra MSB so "no key" is distinct from all 16 codes.
  localparam logic [KEY_W:0] KEY_NONE = 5'h10;
endpackage

// File: rtl/keypad_scanner.sv
// keypad_scanner: rotates a one-hot column drive, resolves the lowest pressed key per scan
// and emits one debounced key event per press.
module keypad_scanner
  import keypad_reg_alu_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [3:0]       key_row,
  output logic [3:0]       key_col,
  output logic             key_evt,
  output logic [KEY_W-1:0] key_code
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [DW-1:0] div_q;
  logic [1:0]    col_q, row_idx;
  logic [KEY_W:0] scan_q, last_q, hit, scan_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, step_end, scan_done;
  assign step_end  = ena && div_q == DW'(SCAN_DIV - 1);
  assign scan_done = step_end && col_q == 2'd3;
  assign row_idx   = key_row[0] ? 2'd0 : key_row[1] ? 2'd1 : key_row[2] ? 2'd2 : 2'd3;
  assign hit       = |key_row ? {1'b0, col_q, row_idx} : KEY_NONE;
  // Columns are visited in ascending order, so the first hit in a scan is the lowest column.
  assign scan_d    = scan_q[KEY_W] ? hit : scan_q;
  assign cnt_d     = scan_d != last_q ? CW'(1) : cnt_q == CW'(DEBOUNCE) ? cnt_q : cnt_q + 1'b1;
  assign key_evt   = scan_done && armed_q && !scan_d[KEY_W] && cnt_d == CW'(DEBOUNCE);
  assign key_code  = scan_d[KEY_W-1:0];
  assign key_col   = 4'b0001 << col_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      col_q   <= '0;
      scan_q  <= KEY_NONE;
      last_q  <= KEY_NONE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else if (ena) begin
      div_q <= step_end ? '0 : div_q + 1'b1;
      if (step_end) begin
        col_q  <= col_q + 1'b1;
        scan_q <= scan_done ? KEY_NONE : scan_d;
      end
      if (scan_done) begin
        last_q  <= scan_d;
        cnt_q   <= cnt_d;
        armed_q <= scan_d[KEY_W] | (armed_q & ~key_evt);
      end
    end
  end
endmodule

// File: rtl/keypad_reg_alu.sv
// keypad_reg_alu: keypad entry buffer, register file and 2-cycle handshaked ALU.
// Define KEYPAD_REG_ALU_MUL_EN to make opcode 111 a multiply instead of an A pass-through.
module keypad_reg_alu
  import keypad_reg_alu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NREGS    = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3,
  localparam int ADDR_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [3:0]        key_row,
  output logic [3:0]        key_col,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [2:0]        op,
  input  logic              op_start,
  output logic              op_ready,
  output logic [DATA_W-1:0] result,
  output logic              res_valid,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [DATA_W-1:0] entry
);
  logic              key_evt;
  logic [KEY_W-1:0]  key_code;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] entry_q, entry_d, a_q, b_q, result_q;
  logic [DATA_W:0]   alu_w;
  logic              carry_q, zero_q;
  op_e               op_q;
  alu_state_e        state_q, state_d;
  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) u_scan (
    .clk(clk), .rst_n(rst_n), .ena(ena), .key_row(key_row),
    .key_col(key_col), .key_evt(key_evt), .key_code(key_code)
  );
  assign entry_d = key_evt ? (wr_en ? DATA_W'(key_code) : {entry_q[DATA_W-5:0], key_code})
                           : (wr_en ? '0 : entry_q);
  assign state_d = state_q == IDLE ? (op_start ? CAPT : IDLE) : state_q == CAPT ? EXEC : IDLE;
`ifdef KEYPAD_REG_ALU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = a_q * b_q;
`endif
  always_comb begin
    alu_w = '0;
    case (op_q)
      OP_ADD: alu_w = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: alu_w = {1'b0, a_q} - {1'b0, b_q};
      OP_AND: alu_w = {1'b0, a_q & b_q};
      OP_OR:  alu_w = {1'b0, a_q | b_q};
      OP_XOR: alu_w = {1'b0, a_q ^ b_q};
      OP_SHL: alu_w = {a_q, 1'b0};
      OP_SHR: alu_w = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
`ifdef KEYPAD_REG_ALU_MUL_EN
      OP_MUL: alu_w = {|prod[2*DATA_W-1:DATA_W], prod[DATA_W-1:0]};
`else
      OP_MUL: alu_w = {1'b0, a_q};
`endif
    endcase
  end
  // Results land at the end of CAPT so they are already stable while res_valid is high in EXEC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      entry_q  <= '0;
      regs_q   <= '{default: '0};
    end else if (ena) begin
      state_q <= state_d;
      entry_q <= entry_d;
      if (wr_en) regs_q[wr_addr] <= entry_q;
      if (state_q == IDLE && op_start) begin
        a_q  <= regs_q[addr_a];
        b_q  <= regs_q[addr_b];
        op_q <= op_e'(op);
      end
      if (state_q == CAPT) begin
        result_q <= alu_w[DATA_W-1:0];
        carry_q  <= alu_w[DATA_W];
        zero_q   <= alu_w[DATA_W-1:0] == '0;
      end
    end
  end
  assign op_ready   = state_q == IDLE;
  assign res_valid  = ena && state_q == EXEC;
  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign entry      = entry_q;
endmodule
